// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation stage: opcodes, format codes
// and the layout of one buffered decode result.
package imm_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Widest supported immediate; narrower configurations use the low bits.
    localparam int IMM_MAX_W = 64;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } imm_fmt_t;

    typedef struct packed {
        logic [31:0]          inst;
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_t             fmt;
        logic                 illegal;
    } imm_ent_t;

    function automatic logic is_shift_f3(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction-format classifier and immediate extractor.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    imm_fmt_t   fmt_sel;
    logic       wide_shamt;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    always_comb begin
        fmt_sel = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR:  fmt_sel = FMT_I;
            OPC_OP_IMM:          fmt_sel = is_shift_f3(funct3) ? FMT_SHAMT : FMT_I;
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    fmt_sel = is_shift_f3(funct3) ? FMT_SHAMT : FMT_I;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE:           fmt_sel = FMT_S;
            OPC_BRANCH:          fmt_sel = FMT_B;
            OPC_LUI, OPC_AUIPC:  fmt_sel = FMT_U;
            OPC_JAL:             fmt_sel = FMT_J;
            OPC_OP, OPC_FENCE, OPC_SYSTEM: fmt_sel = FMT_NONE;
            default:             illegal = 1'b1;
        endcase
    end

    // Only 64-bit OP-IMM shifts carry a 6-bit shamt; word shifts stay at 5 bits.
    assign wide_shamt = (XLEN == 64) && (opcode == OPC_OP_IMM);

    always_comb begin
        imm = '0;
        case (fmt_sel)
            FMT_I:     imm = sext32({{20{inst[31]}}, inst[31:20]});
            FMT_S:     imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
            FMT_B:     imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                     inst[11:8], 1'b0});
            FMT_U:     imm = sext32({inst[31:12], 12'b0});
            FMT_J:     imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                     inst[30:21], 1'b0});
            FMT_SHAMT: imm = wide_shamt ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
            default:   imm = '0;
        endcase
    end

    assign fmt = fmt_sel;

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode at write time into a 2-entry
// FIFO skid buffer with a registered in_ready.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    imm_ent_t        new_ent;

    imm_ent_t   ent_p0;
    imm_ent_t   ent_p1;
    logic [1:0] occ;
    logic [1:0] occ_nxt;
    logic       rdy_q;
    logic       push;
    logic       pop;
    logic       unused_imm;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    always_comb begin
        new_ent.inst    = in_inst;
        new_ent.imm     = IMM_MAX_W'(signed'(dec_imm));
        new_ent.fmt     = imm_fmt_t'(dec_fmt);
        new_ent.illegal = dec_illegal;
    end

    // Reset masks the handshake outputs immediately, not only after an edge.
    assign in_ready  = rdy_q & ~rst;
    assign out_valid = (occ != 2'd0) & ~rst;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        occ_nxt = occ;
        if (rst || flush) begin
            occ_nxt = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   occ_nxt = occ + 2'd1;
                2'b01:   occ_nxt = occ - 2'd1;
                default: occ_nxt = occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ   <= 2'd0;
            rdy_q <= 1'b1;
        end else begin
            occ   <= occ_nxt;
            rdy_q <= (occ_nxt != 2'd2);
        end
    end

    // Buffer storage: ent_p0 is the head, ent_p1 the entry behind it.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            if ((occ == 2'd0) || ((occ == 2'd1) && pop)) begin
                ent_p0 <= new_ent;
            end else begin
                ent_p1 <= new_ent;
            end
        end else if (pop && (occ == 2'd2)) begin
            ent_p0 <= ent_p1;
        end
    end

    assign out_inst    = out_valid ? ent_p0.inst : 32'd0;
    assign out_imm     = out_valid ? ent_p0.imm[XLEN-1:0] : '0;
    assign out_fmt     = out_valid ? ent_p0.fmt : FMT_NONE;
    assign out_illegal = out_valid & ent_p0.illegal;

    // Upper immediate bits are plain sign copies when XLEN is below the maximum.
    assign unused_imm = ^ent_p0.imm;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed table-driven bench for imm_gen_stage (XLEN=32 and XLEN=64 instances).
module tb_imm_gen_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_inst, out_imm;
    logic [2:0]  out_fmt;

    logic        flush64, in_valid64, out_ready64;
    logic [31:0] in_inst64;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [31:0] out_inst64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;

    imm_gen_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    imm_gen_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush64),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_inst(out_inst64),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t v32[10];
    vec_t v64[5];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head32(input string tag, input vec_t v);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " out_inst"}, 64'(out_inst), 64'(v.inst));
        chk({tag, " out_imm"}, 64'(out_imm), v.imm);
        chk({tag, " out_fmt"}, 64'(out_fmt), 64'(v.fmt));
        chk({tag, " out_illegal"}, 64'(out_illegal), 64'(v.ill));
    endtask

    task automatic check_idle32(input string tag);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " out_inst"}, 64'(out_inst), 64'd0);
        chk({tag, " out_imm"}, 64'(out_imm), 64'd0);
        chk({tag, " out_fmt"}, 64'(out_fmt), 64'd0);
        chk({tag, " out_illegal"}, 64'(out_illegal), 64'd0);
    endtask

    initial begin
        v32[0] = '{32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0};
        v32[1] = '{32'hFE112E23, 64'hFFFFFFFC, 3'd2, 1'b0};
        v32[2] = '{32'hFE000CE3, 64'hFFFFFFF8, 3'd3, 1'b0};
        v32[3] = '{32'h123452B7, 64'h12345000, 3'd4, 1'b0};
        v32[4] = '{32'h001000EF, 64'h00000800, 3'd5, 1'b0};
        v32[5] = '{32'h43F0D093, 64'h0000001F, 3'd6, 1'b0};
        v32[6] = '{32'h43F0D09B, 64'h00000000, 3'd0, 1'b1};
        v32[7] = '{32'h00B50533, 64'h00000000, 3'd0, 1'b0};
        v32[8] = '{32'h80012083, 64'hFFFFF800, 3'd1, 1'b0};
        v32[9] = '{32'h0000007F, 64'h00000000, 3'd0, 1'b1};

        v64[0] = '{32'h800002B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
        v64[1] = '{32'h43F0D093, 64'h000000000000003F, 3'd6, 1'b0};
        v64[2] = '{32'h43F0D09B, 64'h000000000000001F, 3'd6, 1'b0};
        v64[3] = '{32'hFFF0009B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
        v64[4] = '{32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = 32'd0; out_ready = 1'b1;
        flush64 = 1'b0; in_valid64 = 1'b0; in_inst64 = 32'd0; out_ready64 = 1'b1;

        // Reset state
        repeat (3) step();
        chk("reset in_ready", 64'(in_ready), 64'd0);
        check_idle32("reset");
        rst = 1'b0;
        #1;
        chk("post-reset in_ready", 64'(in_ready), 64'd1);

        // Streaming, XLEN=32: one result per cycle after one cycle of latency
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_inst  = v32[i].inst;
            step();
            check_head32($sformatf("stream32[%0d]", i), v32[i]);
            chk($sformatf("stream32[%0d] in_ready", i), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream32 drained", 64'(out_valid), 64'd0);

        // Streaming, XLEN=64
        for (int i = 0; i < 5; i++) begin
            in_valid64 = 1'b1;
            in_inst64  = v64[i].inst;
            step();
            chk($sformatf("stream64[%0d] out_valid", i), 64'(out_valid64), 64'd1);
            chk($sformatf("stream64[%0d] out_inst", i), 64'(out_inst64), 64'(v64[i].inst));
            chk($sformatf("stream64[%0d] out_imm", i), out_imm64, v64[i].imm);
            chk($sformatf("stream64[%0d] out_fmt", i), 64'(out_fmt64), 64'(v64[i].fmt));
            chk($sformatf("stream64[%0d] out_illegal", i), 64'(out_illegal64), 64'(v64[i].ill));
        end
        in_valid64 = 1'b0;
        step();
        chk("stream64 drained", 64'(out_valid64), 64'd0);

        // Backpressure: three offered, two accepted, order preserved on release
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = v32[0].inst;
        step();
        chk("bp after 1 in_ready", 64'(in_ready), 64'd1);
        check_head32("bp head A", v32[0]);
        in_inst = v32[1].inst;
        step();
        chk("bp after 2 in_ready", 64'(in_ready), 64'd0);
        check_head32("bp head A held", v32[0]);
        in_inst = v32[2].inst;
        step();
        chk("bp full in_ready", 64'(in_ready), 64'd0);
        check_head32("bp head A stable", v32[0]);
        out_ready = 1'b1;
        step();
        check_head32("bp head B", v32[1]);
        chk("bp release in_ready", 64'(in_ready), 64'd1);
        step();
        check_head32("bp head C", v32[2]);
        in_valid = 1'b0;
        step();
        chk("bp drained", 64'(out_valid), 64'd0);

        // Occupancy 1 with push and pop together: head replaced, no bubble
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = v32[3].inst;
        step();
        check_head32("pp head P", v32[3]);
        out_ready = 1'b1;
        in_inst = v32[4].inst;
        step();
        check_head32("pp head Q", v32[4]);
        chk("pp in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        step();
        chk("pp single entry", 64'(out_valid), 64'd0);

        // Flush with two buffered and a concurrent offer
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = v32[0].inst;
        step();
        in_inst = v32[1].inst;
        step();
        chk("flush pre in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1; in_inst = v32[2].inst;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_idle32("flush full");
        chk("flush full in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        chk("flush stays empty", 64'(out_valid), 64'd0);

        // Flush drops a transfer that would otherwise have been accepted
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = v32[3].inst;
        step();
        flush = 1'b1; in_inst = v32[4].inst;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush drop out_valid", 64'(out_valid), 64'd0);
        chk("flush drop in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = v32[8].inst;
        step();
        check_head32("after flush head", v32[8]);
        in_valid = 1'b0;
        step();
        chk("after flush drained", 64'(out_valid), 64'd0);

        // Reset mid-operation with two entries buffered
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = v32[1].inst;
        step();
        in_inst = v32[2].inst;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid rst in_ready", 64'(in_ready), 64'd0);
        check_idle32("mid rst");
        step();
        chk("mid rst edge in_ready", 64'(in_ready), 64'd0);
        check_idle32("mid rst edge");
        rst = 1'b0;
        #1;
        chk("after rst in_ready", 64'(in_ready), 64'd1);
        chk("after rst out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        for (int i = 3; i < 6; i++) begin
            in_valid = 1'b1;
            in_inst  = v32[i].inst;
            step();
            check_head32($sformatf("resume[%0d]", i), v32[i]);
        end
        in_valid = 1'b0;
        step();
        chk("resume drained", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
